// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master to one-slave pipelined Wishbone arbiter.
// Master 0 = instruction fetch (read-only), master 1 = load-store unit.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   m0_*                  fetch master (adr/cyc/stb in, ack/stall out)
//   m1_*                  LSU master (adr/dat/we/sel/cyc/stb in, ack/stall out)
//   m_dat_o               read data broadcast to both masters
//   s_*                   shared slave port
//   grant_o               one-hot current grant {m1,m0}, 2'b00 = none
//
// Build option:
//   WB_ARB_ROUND_ROBIN_EN  defined   -> ties in IDLE go to the master that
//                                       was not granted last.
//                          undefined -> ties always go to m1 (LSU).

module wb_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    output logic              m0_ack_o,
    output logic              m0_stall_o,

    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [31:0]       m1_dat_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_sel_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    output logic              m1_ack_o,
    output logic              m1_stall_o,

    output logic [31:0]       m_dat_o,

    output logic [ADDR_W-1:0] s_adr_o,
    output logic [31:0]       s_dat_o,
    output logic              s_we_o,
    output logic [3:0]        s_sel_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic              s_ack_i,
    input  logic              s_stall_i,
    input  logic [31:0]       s_dat_i,

    output logic [1:0]        grant_o
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GRANT_M0 = 2'b01,
        GRANT_M1 = 2'b10
    } state_e;

    localparam logic LAST_M0 = 1'b0;
    localparam logic LAST_M1 = 1'b1;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   tie_m1;

    // Who wins when both masters raise cyc in the same IDLE cycle.
`ifdef WB_ARB_ROUND_ROBIN_EN
    assign tie_m1 = (last_q == LAST_M0);
`else
    assign tie_m1 = 1'b1;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= LAST_M1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = tie_m1 ? GRANT_M1 : GRANT_M0;
                end else if (m1_cyc_i) begin
                    state_d = GRANT_M1;
                end else if (m0_cyc_i) begin
                    state_d = GRANT_M0;
                end
            end
            GRANT_M0: begin
                // Grant is held until the owner drops cyc; hand over
                // directly if the other master is already waiting.
                if (!m0_cyc_i) begin
                    last_d  = LAST_M0;
                    state_d = m1_cyc_i ? GRANT_M1 : IDLE;
                end
            end
            GRANT_M1: begin
                if (!m1_cyc_i) begin
                    last_d  = LAST_M1;
                    state_d = m0_cyc_i ? GRANT_M0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: slave-side mux is purely combinational from the
    // registered grant, so a released cyc drops s_cyc_o the same cycle
    // and an async reset clears the bus immediately.
    always_comb begin
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_we_o     = 1'b0;
        s_sel_o    = 4'h0;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        m0_ack_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_ack_o   = 1'b0;
        m1_stall_o = 1'b1;
        case (state_q)
            GRANT_M0: begin
                // Fetch is read-only, full-word.
                s_adr_o    = m0_adr_i;
                s_sel_o    = 4'hF;
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_stb_i;
                m0_ack_o   = s_ack_i;
                m0_stall_o = s_stall_i;
            end
            GRANT_M1: begin
                s_adr_o    = m1_adr_i;
                s_dat_o    = m1_dat_i;
                s_we_o     = m1_we_i;
                s_sel_o    = m1_sel_i;
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_stb_i;
                m1_ack_o   = s_ack_i;
                m1_stall_o = s_stall_i;
            end
            default: begin
                // IDLE: acks with no owner are dropped.
            end
        endcase
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = state_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
// Drives inputs 1ns after the rising edge and samples 3ns after it.

module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] m0_adr_i;
    logic        m0_cyc_i, m0_stb_i, m0_ack_o, m0_stall_o;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_we_i;
    logic [3:0]  m1_sel_i;
    logic        m1_cyc_i, m1_stb_i, m1_ack_o, m1_stall_o;
    logic [31:0] m_dat_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic        s_cyc_o, s_stb_o;
    logic        s_ack_i, s_stall_i;
    logic [31:0] s_dat_i;
    logic [1:0]  grant_o;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam logic [1:0] TIE_WIN  = 2'b01;
    localparam logic [1:0] TIE_LOSE = 2'b10;
`else
    localparam logic [1:0] TIE_WIN  = 2'b10;
    localparam logic [1:0] TIE_LOSE = 2'b01;
`endif

    wb_arbiter #(.ADDR_W(32)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .m0_adr_i   (m0_adr_i),
        .m0_cyc_i   (m0_cyc_i),
        .m0_stb_i   (m0_stb_i),
        .m0_ack_o   (m0_ack_o),
        .m0_stall_o (m0_stall_o),
        .m1_adr_i   (m1_adr_i),
        .m1_dat_i   (m1_dat_i),
        .m1_we_i    (m1_we_i),
        .m1_sel_i   (m1_sel_i),
        .m1_cyc_i   (m1_cyc_i),
        .m1_stb_i   (m1_stb_i),
        .m1_ack_o   (m1_ack_o),
        .m1_stall_o (m1_stall_o),
        .m_dat_o    (m_dat_o),
        .s_adr_o    (s_adr_o),
        .s_dat_o    (s_dat_o),
        .s_we_o     (s_we_o),
        .s_sel_o    (s_sel_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_ack_i    (s_ack_i),
        .s_stall_i  (s_stall_i),
        .s_dat_i    (s_dat_i),
        .grant_o    (grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni    = 1'b0;
        m0_adr_i  = '0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_adr_i  = '0; m1_dat_i = '0; m1_we_i = 0;
        m1_sel_i  = '0; m1_cyc_i = 0; m1_stb_i = 0;
        s_ack_i   = 0; s_stall_i = 0; s_dat_i = 32'h5A5A_0001;

        // Reset state
        #3;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_cyc", s_cyc_o, 1'b0);
        chk("rst_stb", s_stb_o, 1'b0);
        chk("rst_m0_stall", m0_stall_o, 1'b1);
        chk("rst_m1_stall", m1_stall_o, 1'b1);
        chk("rst_adr", s_adr_o, 32'h0);
        chk("rst_mdat", m_dat_o, 32'h5A5A_0001);
        tick();
        rst_ni = 1'b1;

        // Single fetch
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100;
        #2;
        chk("f_idle_grant", grant_o, 2'b00);
        chk("f_idle_stall", m0_stall_o, 1'b1);
        tick(); #2;
        chk("f_grant", grant_o, 2'b01);
        chk("f_adr", s_adr_o, 32'h100);
        chk("f_sel", s_sel_o, 4'hF);
        chk("f_we", s_we_o, 1'b0);
        chk("f_cyc", s_cyc_o, 1'b1);
        chk("f_stb", s_stb_o, 1'b1);
        chk("f_stall", m0_stall_o, 1'b0);
        chk("f_m1_stall", m1_stall_o, 1'b1);
        tick();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        #2;
        chk("f_ack", m0_ack_o, 1'b1);
        chk("f_dat", m_dat_o, 32'hDEAD_BEEF);
        chk("f_m1_ack", m1_ack_o, 1'b0);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        #2;
        chk("f_rel_cyc", s_cyc_o, 1'b0);
        chk("f_rel_grant", grant_o, 2'b01);
        tick(); #2;
        chk("f_idle_after", grant_o, 2'b00);

        // Acks with no grant are dropped
        s_ack_i = 1;
        #1;
        chk("idle_ack_m0", m0_ack_o, 1'b0);
        chk("idle_ack_m1", m1_ack_o, 1'b0);
        s_ack_i = 0;

        // LSU store with slave stall
        tick();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1;
        m1_sel_i = 4'h3; m1_dat_i = 32'h1234; m1_adr_i = 32'h400;
        s_stall_i = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("st_grant", grant_o, 2'b10);
            chk("st_stall", m1_stall_o, 1'b1);
            chk("st_stb", s_stb_o, 1'b1);
            chk("st_we", s_we_o, 1'b1);
            chk("st_sel", s_sel_o, 4'h3);
            chk("st_dat", s_dat_o, 32'h1234);
            tick();
        end
        s_stall_i = 0; s_ack_i = 1;
        #2;
        chk("st_unstall", m1_stall_o, 1'b0);
        chk("st_ack_m1", m1_ack_o, 1'b1);
        chk("st_ack_m0", m0_ack_o, 1'b0);
        tick();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        tick();

        // Reset in the middle of a GRANT_M1 cycle
        m1_cyc_i = 1; m1_stb_i = 1;
        tick(); #2;
        chk("rm_grant", grant_o, 2'b10);
        chk("rm_cyc", s_cyc_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("rm_cyc_drop", s_cyc_o, 1'b0);
        chk("rm_grant_drop", grant_o, 2'b00);
        chk("rm_m0_stall", m0_stall_o, 1'b1);
        chk("rm_m1_stall", m1_stall_o, 1'b1);
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        rst_ni = 1'b1;

        // Contention right after reset
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h200;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h300;
        #2;
        chk("ct_idle", grant_o, 2'b00);
        tick(); #2;
        chk("ct_win", grant_o, TIE_WIN);
        chk("ct_win_adr", s_adr_o, (TIE_WIN == 2'b01) ? 32'h200 : 32'h300);
        tick();
        if (TIE_WIN == 2'b01) begin
            m0_cyc_i = 0; m0_stb_i = 0;
        end else begin
            m1_cyc_i = 0; m1_stb_i = 0;
        end
        #2;
        chk("ct_rel_cyc", s_cyc_o, 1'b0);
        tick(); #2;
        chk("ct_b2b", grant_o, TIE_LOSE);
        chk("ct_b2b_cyc", s_cyc_o, 1'b1);
        chk("ct_b2b_adr", s_adr_o, (TIE_LOSE == 2'b01) ? 32'h200 : 32'h300);
        tick();
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick(); #2;
        chk("ct_idle_end", grant_o, 2'b00);

        // Grant held while m1 owns the bus
        m1_cyc_i = 1; m1_stb_i = 1;
        tick(); #2;
        chk("hd_grant", grant_o, 2'b10);
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); #2;
            chk("hd_hold", grant_o, 2'b10);
            chk("hd_m0_stall", m0_stall_o, 1'b1);
        end
        tick();
        s_ack_i = 1;
        #2;
        chk("hd_m0_ack", m0_ack_o, 1'b0);
        chk("hd_m1_ack", m1_ack_o, 1'b1);
        tick();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        #2;
        chk("hd_rel", grant_o, 2'b10);
        tick(); #2;
        chk("hd_m0_gets", grant_o, 2'b01);
        tick();
        m0_cyc_i = 0; m0_stb_i = 0;
        tick(); #2;
        chk("hd_idle", grant_o, 2'b00);

        // Same master back to back with m0 idle
        m1_cyc_i = 1; m1_stb_i = 1;
        tick(); #2;
        chk("bb_grant", grant_o, 2'b10);
        tick();
        m1_cyc_i = 0; m1_stb_i = 0;
        #2;
        chk("bb_rel_cyc", s_cyc_o, 1'b0);
        tick();
        m1_cyc_i = 1; m1_stb_i = 1;
        #2;
        chk("bb_idle_gap", grant_o, 2'b00);
        tick(); #2;
        chk("bb_regrant", grant_o, 2'b10);
        tick();
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
